// File: rtl/pe_mac_lane_if.sv
// Bus between the PE-array sequencer and one MAC lane: packed control word,
// operands in, saturated result with its valid pulse and sticky overflow out.
interface pe_mac_lane_if #(
    parameter int PE_BUF_ADDR_WIDTH = 10,
    parameter int OP_WIDTH          = 16
);
    localparam int CTRL_WIDTH = 8 + 2 * PE_BUF_ADDR_WIDTH;

    logic        [CTRL_WIDTH-1:0] i_ctrl;
    logic signed [OP_WIDTH-1:0]   i_dataIn;
    logic signed [OP_WIDTH-1:0]   i_weight;
    logic signed [OP_WIDTH-1:0]   o_peOut;
    logic                         o_writeValid;
    logic                         o_accOverflow;

    modport master (
        output i_ctrl, i_dataIn, i_weight,
        input  o_peOut, o_writeValid, o_accOverflow
    );

    modport slave (
        input  i_ctrl, i_dataIn, i_weight,
        output o_peOut, o_writeValid, o_accOverflow
    );
endinterface

// File: rtl/pe_mac_lane.sv
// Two-stage MAC/ADD/MAX/MOV processing element with a saturating signed
// accumulator, a local partial-sum buffer and a saturated output port.
module pe_mac_lane #(
    parameter int PE_BUF_ADDR_WIDTH = 10,
    parameter int OP_WIDTH          = 16,
    parameter int ACC_WIDTH         = 32,
    parameter int FRAC_BITS         = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_mac_lane_if.slave bus
);
    localparam int CTRL_WIDTH = 8 + 2 * PE_BUF_ADDR_WIDTH;
    localparam int AW         = PE_BUF_ADDR_WIDTH;
    localparam int DEPTH      = 1 << AW;
    localparam int SW         = ACC_WIDTH + 2;
    localparam int PW         = (2 * OP_WIDTH > ACC_WIDTH + 1) ? 2 * OP_WIDTH : ACC_WIDTH + 1;

    localparam logic signed [SW-1:0] ACC_MAX = {{3{1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{3{1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX_A = {{(ACC_WIDTH-OP_WIDTH+1){1'b0}}, {(OP_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN_A = {{(ACC_WIDTH-OP_WIDTH+1){1'b1}}, {(OP_WIDTH-1){1'b0}}};
    localparam logic signed [OP_WIDTH-1:0]  OUT_MAX   = {1'b0, {(OP_WIDTH-1){1'b1}}};
    localparam logic signed [OP_WIDTH-1:0]  OUT_MIN   = {1'b1, {(OP_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MAC = 3'b000,
        OP_ADD = 3'b001,
        OP_MAX = 3'b010,
        OP_MOV = 3'b011
    } OpCode;

    logic [CTRL_WIDTH-1:0] w_ctrl;
    logic [2:0]            w_op;
    logic                  w_en, w_rdReq, w_wrReq, w_wv, w_flush;
    logic [AW-1:0]         w_wrAddr, w_rdAddr;

    assign w_ctrl = bus.i_ctrl;
    assign {w_rdAddr, w_wrAddr, w_flush, w_wv, w_wrReq, w_rdReq, w_en, w_op} = w_ctrl;

    logic signed [2*OP_WIDTH-1:0] w_prodFull, w_prodShift;
    logic signed [PW-1:0]         w_prodWide;

    assign w_prodFull  = (2*OP_WIDTH)'(bus.i_dataIn) * (2*OP_WIDTH)'(bus.i_weight);
    assign w_prodShift = w_prodFull >>> FRAC_BITS;
    assign w_prodWide  = PW'(w_prodShift);

    logic [2:0]                  r_s1Op;
    logic                        r_s1En, r_s1RdReq, r_s1WrReq, r_s1Wv, r_s1Flush;
    logic [AW-1:0]               r_s1WrAddr;
    logic signed [OP_WIDTH-1:0]  r_s1Data;
    logic signed [ACC_WIDTH:0]   r_s1Prod;
    logic signed [ACC_WIDTH-1:0] r_rdData;
    logic signed [ACC_WIDTH-1:0] r_buf [DEPTH];

    // Stage 1: decode, product and the registered buffer read (no write bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Op     <= '0;
            r_s1En     <= 1'b0;
            r_s1RdReq  <= 1'b0;
            r_s1WrReq  <= 1'b0;
            r_s1Wv     <= 1'b0;
            r_s1Flush  <= 1'b0;
            r_s1WrAddr <= '0;
            r_s1Data   <= '0;
            r_s1Prod   <= '0;
            r_rdData   <= '0;
        end else begin
            r_s1Op     <= w_op;
            r_s1En     <= w_en;
            r_s1RdReq  <= w_rdReq;
            r_s1WrReq  <= w_wrReq;
            r_s1Wv     <= w_wv;
            r_s1Flush  <= w_flush;
            r_s1WrAddr <= w_wrAddr;
            r_s1Data   <= bus.i_dataIn;
            r_s1Prod   <= w_prodWide[ACC_WIDTH:0];
            if (w_rdReq) begin
                r_rdData <= r_buf[w_rdAddr];
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_ovf;
    logic signed [OP_WIDTH-1:0]  r_peOut;
    logic                        r_wv;

    logic signed [ACC_WIDTH-1:0] w_base, w_accNext;
    logic signed [SW-1:0]        w_baseExt, w_dataExt, w_wide;
    logic signed [OP_WIDTH-1:0]  w_outSat;
    logic                        w_clamp;

    // Stage 2 datapath: sums are formed two bits wider so a clamp can be detected.
    always_comb begin
        w_base    = r_s1RdReq ? r_rdData : r_acc;
        w_baseExt = SW'(w_base);
        w_dataExt = SW'(r_s1Data);
        w_wide    = w_baseExt;
        if (r_s1En) begin
            case (r_s1Op)
                OP_MAC:  w_wide = w_baseExt + SW'(r_s1Prod);
                OP_ADD:  w_wide = w_baseExt + w_dataExt;
                OP_MAX:  w_wide = (w_dataExt > w_baseExt) ? w_dataExt : w_baseExt;
                OP_MOV:  w_wide = w_dataExt;
                default: w_wide = w_baseExt;
            endcase
        end
        w_clamp   = 1'b0;
        w_accNext = w_wide[ACC_WIDTH-1:0];
        if (w_wide > ACC_MAX) begin
            w_accNext = ACC_MAX[ACC_WIDTH-1:0];
            w_clamp   = 1'b1;
        end else if (w_wide < ACC_MIN) begin
            w_accNext = ACC_MIN[ACC_WIDTH-1:0];
            w_clamp   = 1'b1;
        end
        w_outSat = w_accNext[OP_WIDTH-1:0];
        if (w_accNext > OUT_MAX_A) begin
            w_outSat = OUT_MAX;
        end else if (w_accNext < OUT_MIN_A) begin
            w_outSat = OUT_MIN;
        end
    end

    // Flush wins over a same-cycle clamp, so the sticky flag always clears with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_peOut <= '0;
            r_wv    <= 1'b0;
        end else begin
            r_wv <= r_s1Wv;
            if (r_s1Wv) begin
                r_peOut <= w_outSat;
            end
            if (r_s1Flush) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_accNext;
                if (w_clamp) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Partial-sum spill stores the full-width accumulator value.
    always_ff @(posedge clk) begin
        if (r_s1WrReq) begin
            r_buf[r_s1WrAddr] <= w_accNext;
        end
    end

    assign bus.o_peOut       = r_peOut;
    assign bus.o_writeValid  = r_wv;
    assign bus.o_accOverflow = r_ovf;
endmodule

// File: tb/tb_pe_mac_lane.sv
// Directed plus randomized bench for pe_mac_lane, checked against a sequential
// arithmetic model whose results surface two cycles after issue.
module tb_pe_mac_lane;
    localparam int AW   = 10;
    localparam int OPW  = 16;
    localparam int ACCW = 32;
    localparam int FRAC = 0;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pe_mac_lane_if #(.PE_BUF_ADDR_WIDTH(AW), .OP_WIDTH(OPW)) intf();

    pe_mac_lane #(
        .PE_BUF_ADDR_WIDTH(AW),
        .OP_WIDTH(OPW),
        .ACC_WIDTH(ACCW),
        .FRAC_BITS(FRAC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(intf)
    );

    typedef struct {
        bit wv;
        int out;
        bit ovf;
    } ExpT;

    ExpT    expQ[$];
    longint mAcc;
    bit     mOvf;
    int     mPeOut;
    longint mBuf[int];
    bit     lastWr;
    int     lastWrA;
    int     nCompared   = 0;
    int     nMismatched = 0;

    function automatic longint clampAcc(input longint v, output bit c);
        longint hi = (longint'(1) <<< (ACCW - 1)) - 1;
        longint lo = -(longint'(1) <<< (ACCW - 1));
        c = 1'b0;
        if (v > hi) begin
            c = 1'b1;
            return hi;
        end
        if (v < lo) begin
            c = 1'b1;
            return lo;
        end
        return v;
    endfunction

    function automatic int clampOut(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic checkOutput();
        ExpT e;
        e = expQ.pop_front();
        nCompared += 3;
        assert (intf.o_writeValid === e.wv) else begin
            nMismatched++;
            $error("[TB] FAIL writeValid: observed %0b expected %0b", intf.o_writeValid, e.wv);
        end
        assert (intf.o_peOut === OPW'(e.out)) else begin
            nMismatched++;
            $error("[TB] FAIL peOut: observed %0d expected %0d", $signed(intf.o_peOut), e.out);
        end
        assert (intf.o_accOverflow === e.ovf) else begin
            nMismatched++;
            $error("[TB] FAIL accOverflow: observed %0b expected %0b", intf.o_accOverflow, e.ovf);
        end
    endtask

    task automatic checkValue(input string tag, input int val, input bit ovf);
        nCompared += 3;
        assert (intf.o_writeValid === 1'b1) else begin
            nMismatched++;
            $error("[TB] FAIL %s valid: observed %0b expected 1", tag, intf.o_writeValid);
        end
        assert (intf.o_peOut === OPW'(val)) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(intf.o_peOut), val);
        end
        assert (intf.o_accOverflow === ovf) else begin
            nMismatched++;
            $error("[TB] FAIL %s ovf: observed %0b expected %0b", tag, intf.o_accOverflow, ovf);
        end
    endtask

    task automatic checkIdle(input string tag);
        nCompared++;
        assert ({intf.o_writeValid, intf.o_accOverflow, intf.o_peOut} === '0) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed wv=%0b ovf=%0b out=%0d expected all zero", tag,
                   intf.o_writeValid, intf.o_accOverflow, $signed(intf.o_peOut));
        end
    endtask

    // One op per cycle; the model executes it in program order immediately.
    task automatic applyStimulus(input int op, input bit en, input bit rd, input bit wr,
                                 input bit wv, input bit fl, input int rdA, input int wrA,
                                 input int d, input int w);
        longint base, r, prod;
        bit     c;
        intf.i_ctrl   = {AW'(rdA), AW'(wrA), fl, wv, wr, rd, en, 3'(op)};
        intf.i_dataIn = OPW'(d);
        intf.i_weight = OPW'(w);
        base = rd ? mBuf[rdA] : mAcc;
        prod = (longint'(d) * longint'(w)) >>> FRAC;
        c    = 1'b0;
        r    = base;
        if (en) begin
            case (op)
                0:       r = clampAcc(base + prod, c);
                1:       r = clampAcc(base + longint'(d), c);
                2:       r = (longint'(d) > base) ? longint'(d) : base;
                3:       r = longint'(d);
                default: r = base;
            endcase
        end
        if (wr) mBuf[wrA] = r;
        if (wv) mPeOut = clampOut(r);
        if (fl) begin
            mAcc = 0;
            mOvf = 1'b0;
        end else begin
            mAcc = r;
            if (c) mOvf = 1'b1;
        end
        expQ.push_back('{wv, mPeOut, mOvf});
        lastWr  = wr;
        lastWrA = wrA;
        @(posedge clk);
        #1;
        if (expQ.size() >= 2) checkOutput();
    endtask

    task automatic nop(input bit fl);
        applyStimulus(4, 1'b0, 1'b0, 1'b0, 1'b0, fl, 0, 0, 0, 0);
    endtask

    function automatic int randOperand();
        logic signed [15:0] t;
        if ($urandom_range(0, 3) == 0) begin
            t = 16'($urandom);
            return int'(t);
        end
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    function automatic int randAddr();
        int idx = int'($urandom_range(0, 8));
        return (idx == 8) ? 1023 : idx;
    endfunction

    initial begin
        rst_n         = 1'b0;
        intf.i_ctrl   = '0;
        intf.i_dataIn = '0;
        intf.i_weight = '0;
        mAcc = 0; mOvf = 1'b0; mPeOut = 0; lastWr = 1'b0; lastWrA = 0;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("inReset");
        rst_n = 1'b1;

        $display("[TB] idle after reset");
        repeat (10) nop(1'b0);
        checkIdle("idle");

        $display("[TB] MAC chain");
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 3, 5);
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 3, 5);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        checkValue("macChain", 60, 1'b0);
        nop(1'b1);
        checkValue("macAfterFlush", 1, 1'b0);

        $display("[TB] saturation");
        applyStimulus(3, 1, 0, 0, 0, 0, 0, 0, 32767, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 32767, 32767);
        nop(1'b0);
        checkValue("satOut", 32767, 1'b1);
        nop(1'b1);
        nop(1'b0);
        nCompared++;
        assert (intf.o_accOverflow === 1'b0) else begin
            nMismatched++;
            $error("[TB] FAIL ovfClear: observed %0b expected 0", intf.o_accOverflow);
        end

        $display("[TB] buffer spill and reload");
        applyStimulus(3, 1, 0, 1, 0, 0, 0, 5, 100, 0);
        nop(1'b1);
        nop(1'b0);
        nop(1'b0);
        applyStimulus(1, 1, 1, 0, 1, 0, 5, 0, 7, 0);
        nop(1'b1);
        checkValue("reload5", 107, 1'b0);
        applyStimulus(3, 1, 0, 1, 0, 0, 0, 1023, -12345, 0);
        nop(1'b1);
        nop(1'b0);
        applyStimulus(1, 1, 1, 0, 1, 0, 1023, 0, 0, 0);
        nop(1'b1);
        checkValue("reload1023", -12345, 1'b0);

        $display("[TB] MAX and NOP");
        applyStimulus(3, 1, 0, 0, 0, 0, 0, 0, -20, 0);
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 0, 13, 0);
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 0, -50, 0);
        applyStimulus(6, 1, 0, 0, 1, 0, 0, 0, 99, 99);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 9, 9);
        checkValue("maxNop", 13, 1'b0);
        nop(1'b1);
        checkValue("enableLow", 13, 1'b0);

        $display("[TB] async reset mid-stream");
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 50, 50);
        rst_n       = 1'b0;
        intf.i_ctrl = '0;
        #1;
        checkIdle("midReset");
        @(posedge clk);
        #1;
        checkIdle("noPulse");
        rst_n = 1'b1;
        expQ.delete();
        mAcc = 0; mOvf = 1'b0; mPeOut = 0;
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 4, 0);
        nop(1'b0);
        checkValue("postReset", 4, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            int  rdA = randAddr();
            int  wrA = randAddr();
            bit  rd  = 1'b0;
            if ($urandom_range(0, 3) == 0 && mBuf.exists(rdA) && !(lastWr && lastWrA == rdA))
                rd = 1'b1;
            applyStimulus(int'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0), rd,
                          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), rdA, wrA, randOperand(), randOperand());
        end
        nop(1'b0);
        nop(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/pe_mac_lane.md
Name: pe_mac_lane

Overview:
- Parametrised processing element for the DNN accelerator datapath; successor to the control-decode-only PE stub.
- Decodes the packed PE control word and executes MAC, ADD, MAX or MOV on a signed accumulator.
- Keeps partial sums in a local PE buffer (reload/spill) and emits saturated results to the memory-controller write path with a matched write_valid.
- Sits between the PE-array control sequencer and the output write FIFO.

Parameters:
- PE_BUF_ADDR_WIDTH, 10: PE buffer address width; depth = 2**PE_BUF_ADDR_WIDTH.
- OP_WIDTH, 16: signed operand and output width.
- ACC_WIDTH, 32: signed accumulator and buffer word width; must be >= OP_WIDTH.
- FRAC_BITS, 0: arithmetic right shift applied to the product before accumulation.
- CTRL_WIDTH, 8+2*PE_BUF_ADDR_WIDTH: derived control word width; not to be overridden.

Ports:
- clk, in, 1: clock; all state is rising-edge.
- reset, in, 1: asynchronous, active-low reset.
- ctrl, in, CTRL_WIDTH: packed control word, MSB to LSB {buf_rd_addr, buf_wr_addr, flush, write_valid, pe_buffer_write_req, pe_buffer_read_req, enable, op_code[2:0]}.
- data_in, in, OP_WIDTH: signed activation.
- weight, in, OP_WIDTH: signed weight.
- pe_out, out, OP_WIDTH: saturated result.
- write_valid, out, 1: pe_out valid; one-cycle pulse per request.
- acc_overflow, out, 1: sticky flag; set on any accumulator saturation, cleared by flush.

Behaviour:
- Reset (reset=0, async): all pipeline registers, acc, pe_out, write_valid and acc_overflow go to 0. Buffer contents are not reset and are undefined after power-up. A reset mid-operation drops all in-flight ops with no output pulse.
- Stage 1 (edge after cycle t registers):
  - The decoded ctrl fields.
  - prod = (data_in*weight) >>> FRAC_BITS, full 2*OP_WIDTH signed, then sign-extended or truncated to ACC_WIDTH+1 bits.
  - If pe_buffer_read_req=1: rd_data = buf[buf_rd_addr]. This is a synchronous read that returns old data on a same-cycle write to the same address; there is no bypass.
- Stage 2 (edge after cycle t+1):
  - base = rd_data if the stage-1 read_req is set, else acc (partial-sum reload).
  - If enable=1, op selects acc_next:
    - 000 MAC: base+prod.
    - 001 ADD: base+sext(data_in).
    - 010 MAX: max(base, sext(data_in)).
    - 011 MOV: sext(data_in).
    - 1xx: NOP, acc_next = base.
  - If enable=0: acc_next = base (a reload still applies).
  - Additions saturate to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets acc_overflow.
  - pe_buffer_write_req=1: buf[buf_wr_addr] <= acc_next, full ACC_WIDTH, unsaturated to OP_WIDTH.
  - write_valid bit=1: pe_out <= sat_OP(acc_next) and write_valid output=1. Otherwise write_valid=0 and pe_out holds.
  - flush=1: acc <= 0 after acc_next is used for write/output, and acc_overflow clears. A saturation in the same cycle still clears, because flush wins. Otherwise acc <= acc_next.
- Latency: ctrl/data presented at cycle t produce write_valid/pe_out visible at cycle t+2. Fully pipelined, one op per cycle, no stalls or backpressure.
- Back-to-back ops: op at t+1 uses acc updated by op at t. The accumulator forwards internally, so no bubble is needed.
- sat_OP clamps acc_next to [-2^(OP_WIDTH-1), 2^(OP_WIDTH-1)-1].
- Buffer address wrap: addresses are modulo depth by construction. Same-address stage-2 write plus new read returns old data; the sequencer must space such accesses by two cycles.

Test Plan:
- Reset/idle: hold reset=0, then release with ctrl=0 for 10 cycles -> pe_out=0, write_valid=0, acc_overflow=0 throughout.
- MAC chain: 4 cycles MAC with enable=1, data_in=3, weight=5; the 4th cycle also has write_valid=1 and flush=1 -> single write_valid pulse 2 cycles later with pe_out=60. A following MAC 1*1 with write_valid outputs 1, proving the clear.
- Saturation: MOV 32767, then MAC 32767*32767 repeated 3 times with write_valid -> pe_out=32767 and acc_overflow=1. After a flush, acc_overflow=0.
- Buffer spill/reload:
  - MOV 100 with write_req, wr_addr=5, then flush.
  - Later ADD data_in=7 with read_req, rd_addr=5, write_valid -> pe_out=107.
  - Also rd_addr=1023 / wr_addr=1023 round-trip.
- MAX and NOP: MOV -20, MAX 13, MAX -50, then op 3'b110 with write_valid -> pe_out=13. enable=0 MAC with write_valid -> pe_out unchanged, 13.
- Async reset mid-stream: assert reset between a MAC issue and its output cycle -> no write_valid pulse. After release, acc=0, so ADD 4 with write_valid yields pe_out=4.
